round_overflow_stage: RTL and testbench
=======================================

# round_overflow_stage

Rounding and exception-detection stage that sits directly upstream of the final IEEE result-packing stage of the add/subtract pipeline. It accepts a normalized sign/exponent/extended significand with guard, round and sticky bits, and applies the selected IEEE rounding mode. It renormalizes on round carry-out and flags overflow or underflow. It then presents sign, exponent, fraction and the two mux-select flags, with a one-cycle load pulse for the packing register.

## Interface
- W, 32: total IEEE word width (32 single, 64 double).
- EW, 8: exponent width (8 single, 11 double).
- SW, 23: stored fraction width (23 single, 52 double).

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle request; inputs sampled when start_i=1 in IDLE.
- rmode_i  in  2  rounding mode: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf.
- sign_i  in  1  result sign.
- exp_i  in  EW+1  biased exponent, one extra MSB for overflow headroom, unsigned.
- sgf_i  in  SW+4  bit SW+3 hidden bit, [SW+2:3] fraction, bit 2 guard, bit 1 round, bit 0 sticky.
- sign_o  out  1  registered sign.
- exp_o  out  EW  rounded biased exponent.
- sgf_o  out  SW  rounded fraction, hidden bit dropped.
- sel_a_o  out  1  overflow flag; selects the infinity encoding downstream.
- sel_b_o  out  1  underflow flag; selects the flush encoding downstream.
- load_o  out  1  one-cycle pulse; the downstream register loads on it.
- busy_o  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ROUND, ADJUST, DONE.
  - IDLE→ROUND on start_i.
  - ROUND→ADJUST, ADJUST→DONE and DONE→IDLE are unconditional.
- IDLE with start_i=1: capture sign_i, exp_i, sgf_i and rmode_i into internal registers.
- ROUND: compute increment inc from guard g, round r, sticky s and LSB l = sgf[3].
  - RNE: inc = g & (r | s | l).
  - RZ: inc = 0.
  - +inf: inc = ~sign & (g | r | s).
  - -inf: inc = sign & (g | r | s).
  - Register sum = {1'b0, sgf[SW+3:3]} + inc; sum is SW+2 bits.
- ADJUST:
  - If sum[SW+1]=1: mantissa = sum[SW+1:1] and exp = exp+1.
  - Otherwise: mantissa = sum[SW:0] and exp unchanged.
  - Overflow when the adjusted exp ≥ 2^EW−1.
  - Underflow when captured exp_i = 0 or captured hidden bit = 0; subnormals are flushed.
  - Overflow has priority, so sel_a_o and sel_b_o are never both 1.
- DONE: outputs registered; load_o=1 for exactly this cycle.
  - exp_o = adjusted exp[EW-1:0].
  - sgf_o = mantissa[SW-1:0].
  - sign_o = captured sign.
  - When either flag is set, exp_o/sgf_o carry don't-care values; downstream substitutes its own constants.
- start_i while busy_o=1 is ignored: not queued, no effect.
- Outputs hold their last values until the next DONE.

## Timing
- Reset (rst=0, asynchronous): state=IDLE; sign_o, exp_o, sgf_o, sel_a_o, sel_b_o, load_o and busy_o all 0.
- Latency: start_i sampled in cycle 0 → ROUND in cycle 1 → ADJUST in cycle 2 → DONE with load_o=1 in cycle 3.
- busy_o is high in cycles 1–3.
- Throughput: one operation per 4 cycles. start_i in the cycle after DONE is accepted.
- Reset asserted mid-operation aborts: no load_o pulse, and outputs return to 0 immediately.
- Reset deassertion takes effect on the next rising edge; the first start is accepted no earlier than that edge.

## Structure
- Shared package:
  - rounding-mode constants (RM_NE, RM_RZ, RM_PINF, RM_NINF);
  - FSM state encoding (2-bit);
  - exponent-max constant derived from EW.
- One combinational sub-module, round_incr_logic: inputs rmode, sign, l, g, r, s; output inc. It is reused by the multiply datapath.
- The FSM, capture registers and output registers live in the top module.

## Test plan
- Exact 1.0, W=32: exp_i=127, sgf_i={1'b1, 23'h0, 3'b000}, RNE → cycle 3: load_o=1, exp_o=8'h7F, sgf_o=0, flags 0.
- Tie-to-even: fraction 23'h000001, grs=100, RNE → sgf_o=23'h000002. Fraction 23'h000000, grs=100 → sgf_o=0.
- Carry-out: fraction 23'h7FFFFF, grs=110, exp_i=127, RNE → exp_o=8'h80, sgf_o=0.
- Overflow: exp_i=254, fraction 23'h7FFFFF, grs=111, RNE → sel_a_o=1, sel_b_o=0. The same input with RZ → sel_a_o=0, exp_o=8'hFE.
- Underflow: exp_i=0, any sgf_i → sel_b_o=1, sel_a_o=0.
- Control:
  - start_i pulsed in cycles 1 and 2 → ignored; exactly one load_o.
  - rst pulled low in cycle 2 → no load_o, all outputs 0, next start completes normally.

Source files
------------

// File: rtl/round_overflow_stage_pkg.sv
// Shared constants for the add/sub rounding stage: rounding modes, FSM encoding
// and the exponent ceiling that marks overflow.
package round_overflow_stage_pkg;

  localparam logic [1:0] RM_NE   = 2'b00;
  localparam logic [1:0] RM_RZ   = 2'b01;
  localparam logic [1:0] RM_PINF = 2'b10;
  localparam logic [1:0] RM_NINF = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUND  = 2'd1,
    ST_ADJUST = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned EW_SP = 8;
  localparam int unsigned EW_DP = 11;

  // All-ones biased exponent: anything at or above it encodes infinity.
  function automatic int unsigned exp_max(input int unsigned ew);
    return (32'd1 << ew) - 32'd1;
  endfunction

  localparam int unsigned EXP_MAX_SP = exp_max(EW_SP);
  localparam int unsigned EXP_MAX_DP = exp_max(EW_DP);

endpackage

// File: rtl/round_overflow_stage_round_incr_logic.sv
// Round-up decision from guard/round/sticky and the result LSB; shared with
// the multiply datapath.
module round_incr_logic
  import round_overflow_stage_pkg::*;
(
  input  logic [1:0] rmode,
  input  logic       sign,
  input  logic       l,
  input  logic       g,
  input  logic       r,
  input  logic       s,
  output logic       inc
);

  logic w_inexact;

  always_comb begin
    w_inexact = g | r | s;
    inc       = 1'b0;
    unique case (rmode)
      RM_NE:   inc = g & (r | s | l);
      RM_RZ:   inc = 1'b0;
      RM_PINF: inc = ~sign & w_inexact;
      RM_NINF: inc = sign & w_inexact;
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/round_overflow_stage.sv
// Rounds a normalized sign/exponent/significand, renormalizes on carry-out and
// flags overflow/underflow for the IEEE packing register that follows.
module round_overflow_stage
  import round_overflow_stage_pkg::*;
#(
  parameter int W  = 32,
  parameter int EW = 8,
  parameter int SW = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [1:0]    rmode_i,
  input  logic          sign_i,
  input  logic [EW:0]   exp_i,
  input  logic [SW+3:0] sgf_i,
  output logic          sign_o,
  output logic [EW-1:0] exp_o,
  output logic [SW-1:0] sgf_o,
  output logic          sel_a_o,
  output logic          sel_b_o,
  output logic          load_o,
  output logic          busy_o
);

  localparam logic [EW+1:0] EXP_MAX = (EW+2)'(exp_max(EW));

  if (W != EW + SW + 1) begin : g_bad_cfg
    $error("round_overflow_stage: W must equal EW + SW + 1");
  end

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_sign_p0;
  logic [1:0]      r_rmode_p0;
  logic [EW:0]     r_exp_p0;
  logic [SW+3:0]   r_sgf_p0;

  logic [SW+1:0]   r_sum_p1;

  logic            w_inc;
  logic            w_carry;
  logic [SW-1:0]   w_frac;
  logic [EW+1:0]   w_exp_adj;
  logic            w_ovf;
  logic            w_unf;

  logic            r_sign;
  logic [EW-1:0]   r_exp;
  logic [SW-1:0]   r_sgf;
  logic            r_sel_a;
  logic            r_sel_b;
  logic            r_load;

  function automatic logic is_overflow(input logic [EW+1:0] e);
    return (e >= EXP_MAX);
  endfunction

  function automatic logic is_underflow(input logic [EW:0] e, input logic hidden);
    return (e == '0) | ~hidden;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (start_i) w_state_nxt = ST_ROUND;
      ST_ROUND:  w_state_nxt = ST_ADJUST;
      ST_ADJUST: w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: operand capture; starts while busy are dropped by the IDLE gate.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && start_i) begin
      r_sign_p0  <= sign_i;
      r_rmode_p0 <= rmode_i;
      r_exp_p0   <= exp_i;
      r_sgf_p0   <= sgf_i;
    end
  end

  round_incr_logic u_incr (
    .rmode (r_rmode_p0),
    .sign  (r_sign_p0),
    .l     (r_sgf_p0[3]),
    .g     (r_sgf_p0[2]),
    .r     (r_sgf_p0[1]),
    .s     (r_sgf_p0[0]),
    .inc   (w_inc)
  );

  // Stage p1: rounded significand with one bit of carry headroom.
  always_ff @(posedge clk) begin
    if (r_state == ST_ROUND) begin
      r_sum_p1 <= {1'b0, r_sgf_p0[SW+3:3]} + (SW+2)'(w_inc);
    end
  end

  always_comb begin
    w_carry   = r_sum_p1[SW+1];
    w_frac    = w_carry ? r_sum_p1[SW:1] : r_sum_p1[SW-1:0];
    w_exp_adj = {1'b0, r_exp_p0} + (EW+2)'(w_carry);
    w_ovf     = is_overflow(w_exp_adj);
    w_unf     = is_underflow(r_exp_p0, r_sgf_p0[SW+3]);
  end

  // Stage p2: output register, loaded on the ADJUST->DONE edge so DONE carries the pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_sgf   <= '0;
      r_sel_a <= 1'b0;
      r_sel_b <= 1'b0;
      r_load  <= 1'b0;
    end else begin
      r_load <= (r_state == ST_ADJUST);
      if (r_state == ST_ADJUST) begin
        r_sign  <= r_sign_p0;
        r_exp   <= w_exp_adj[EW-1:0];
        r_sgf   <= w_frac;
        r_sel_a <= w_ovf;
        r_sel_b <= w_unf & ~w_ovf;
      end
    end
  end

  assign sign_o  = r_sign;
  assign exp_o   = r_exp;
  assign sgf_o   = r_sgf;
  assign sel_a_o = r_sel_a;
  assign sel_b_o = r_sel_b;
  assign load_o  = r_load;
  assign busy_o  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_round_overflow_stage.sv
// Bench for round_overflow_stage (single precision): directed cases with literal
// expectations plus randomized traffic checked every cycle against an arithmetic model.
module tb_round_overflow_stage;

  localparam int EW = 8;
  localparam int SW = 23;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic [1:0]    rmode_i = 2'b00;
  logic          sign_i = 1'b0;
  logic [EW:0]   exp_i = '0;
  logic [SW+3:0] sgf_i = '0;
  logic          sign_o;
  logic [EW-1:0] exp_o;
  logic [SW-1:0] sgf_o;
  logic          sel_a_o;
  logic          sel_b_o;
  logic          load_o;
  logic          busy_o;

  round_overflow_stage #(.W(32), .EW(EW), .SW(SW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .rmode_i (rmode_i),
    .sign_i  (sign_i),
    .exp_i   (exp_i),
    .sgf_i   (sgf_i),
    .sign_o  (sign_o),
    .exp_o   (exp_o),
    .sgf_o   (sgf_o),
    .sel_a_o (sel_a_o),
    .sel_b_o (sel_b_o),
    .load_o  (load_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  typedef struct packed {
    logic        sign;
    logic        a;
    logic        b;
    logic [7:0]  e;
    logic [22:0] f;
  } res_t;

  // Reference: round the 24-bit significand as an integer, renormalize by halving.
  function automatic res_t ref_round(input logic sg, input int unsigned e_in,
                                     input logic [26:0] s_in, input logic [1:0] rm);
    int unsigned mant;
    int unsigned e;
    int unsigned inc;
    bit g, r, s, inexact;
    res_t o;
    mant    = 32'(s_in[26:3]);
    e       = e_in;
    g       = s_in[2];
    r       = s_in[1];
    s       = s_in[0];
    inexact = g || r || s;
    case (rm)
      2'd0:    inc = (g && (r || s || (mant % 2 == 1))) ? 1 : 0;
      2'd1:    inc = 0;
      2'd2:    inc = (!sg && inexact) ? 1 : 0;
      default: inc = (sg && inexact) ? 1 : 0;
    endcase
    mant = mant + inc;
    if (mant >= 32'h0100_0000) begin
      mant = mant / 2;
      e    = e + 1;
    end
    o.sign = sg;
    o.a    = (e >= 255);
    o.b    = !o.a && (e_in == 0 || s_in[26] == 1'b0);
    o.e    = e[7:0];
    o.f    = mant[22:0];
    return o;
  endfunction

  // Cycle-level expectation: accepted op surfaces 3 edges later with a single load.
  int   cnt = 0;
  res_t pend = '0;
  res_t m_out = '0;
  logic m_load = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    = 0;
      m_load = 1'b0;
      m_out  = '0;
    end else begin
      m_load = 1'b0;
      case (cnt)
        0: if (start_i) begin
             pend = ref_round(sign_i, 32'(exp_i), sgf_i, rmode_i);
             cnt  = 1;
           end
        1: cnt = 2;
        2: begin
             cnt    = 3;
             m_out  = pend;
             m_load = 1'b1;
           end
        default: cnt = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("cyc_load",  32'(load_o),  32'(m_load));
    chk("cyc_busy",  32'(busy_o),  32'(cnt != 0));
    chk("cyc_sign",  32'(sign_o),  32'(m_out.sign));
    chk("cyc_sel_a", 32'(sel_a_o), 32'(m_out.a));
    chk("cyc_sel_b", 32'(sel_b_o), 32'(m_out.b));
    if (!m_out.a && !m_out.b) begin
      chk("cyc_exp", 32'(exp_o), 32'(m_out.e));
      chk("cyc_sgf", 32'(sgf_o), 32'(m_out.f));
    end
  end

  // Called at posedge+2 in IDLE; returns at posedge+2 of the cycle after DONE.
  task automatic op(input string nm, input logic sg, input logic [8:0] e,
                    input logic [26:0] s, input logic [1:0] rm,
                    input logic [7:0] xe, input logic [22:0] xf,
                    input logic xa, input logic xb, input bit cmp_data);
    start_i = 1'b1;
    sign_i  = sg;
    exp_i   = e;
    sgf_i   = s;
    rmode_i = rm;
    @(posedge clk); #2;
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk({nm, "_load"},  32'(load_o),  32'd1);
    chk({nm, "_sel_a"}, 32'(sel_a_o), 32'(xa));
    chk({nm, "_sel_b"}, 32'(sel_b_o), 32'(xb));
    chk({nm, "_sign"},  32'(sign_o),  32'(sg));
    if (cmp_data) begin
      chk({nm, "_exp"}, 32'(exp_o), 32'(xe));
      chk({nm, "_sgf"}, 32'(sgf_o), 32'(xf));
    end
    @(posedge clk); #2;
    chk({nm, "_load_drop"}, 32'(load_o), 32'd0);
  endtask

  res_t r;
  logic [8:0]  rnd_e;
  logic [22:0] rnd_f;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_load",  32'(load_o),  32'd0);
    chk("rst_busy",  32'(busy_o),  32'd0);
    chk("rst_exp",   32'(exp_o),   32'd0);
    chk("rst_sgf",   32'(sgf_o),   32'd0);
    chk("rst_flags", 32'({sel_a_o, sel_b_o, sign_o}), 32'd0);
    rst = 1'b1;
    @(posedge clk); #2;

    r = ref_round(1'b0, 127, {1'b1, 23'h000001, 3'b100}, 2'd0);
    chk("model_tie_odd", 32'(r.f), 32'h000002);
    r = ref_round(1'b0, 127, {1'b1, 23'h7FFFFF, 3'b110}, 2'd0);
    chk("model_carry", 32'({r.e, r.f}), 32'({8'h80, 23'h0}));
    r = ref_round(1'b0, 254, {1'b1, 23'h7FFFFF, 3'b111}, 2'd0);
    chk("model_ovf", 32'({r.a, r.b}), 32'b10);

    op("one",      1'b0, 9'd127, {1'b1, 23'h000000, 3'b000}, 2'd0, 8'h7F, 23'h000000, 1'b0, 1'b0, 1'b1);
    op("tie_odd",  1'b0, 9'd127, {1'b1, 23'h000001, 3'b100}, 2'd0, 8'h7F, 23'h000002, 1'b0, 1'b0, 1'b1);
    op("tie_even", 1'b0, 9'd127, {1'b1, 23'h000000, 3'b100}, 2'd0, 8'h7F, 23'h000000, 1'b0, 1'b0, 1'b1);
    op("carry",    1'b0, 9'd127, {1'b1, 23'h7FFFFF, 3'b110}, 2'd0, 8'h80, 23'h000000, 1'b0, 1'b0, 1'b1);
    op("ovf_rne",  1'b0, 9'd254, {1'b1, 23'h7FFFFF, 3'b111}, 2'd0, 8'h00, 23'h000000, 1'b1, 1'b0, 1'b0);
    op("ovf_rz",   1'b0, 9'd254, {1'b1, 23'h7FFFFF, 3'b111}, 2'd1, 8'hFE, 23'h7FFFFF, 1'b0, 1'b0, 1'b1);
    op("unf",      1'b1, 9'd0,   {1'b1, 23'h123456, 3'b101}, 2'd0, 8'h00, 23'h000000, 1'b0, 1'b1, 1'b0);
    op("pinf_pos", 1'b0, 9'd100, {1'b1, 23'h000005, 3'b001}, 2'd2, 8'h64, 23'h000006, 1'b0, 1'b0, 1'b1);
    op("pinf_neg", 1'b1, 9'd100, {1'b1, 23'h000005, 3'b001}, 2'd2, 8'h64, 23'h000005, 1'b0, 1'b0, 1'b1);
    op("ninf_neg", 1'b1, 9'd100, {1'b1, 23'h000005, 3'b001}, 2'd3, 8'h64, 23'h000006, 1'b0, 1'b0, 1'b1);

    // Starts during ROUND and ADJUST must not disturb the op in flight.
    start_i = 1'b1; sign_i = 1'b0; exp_i = 9'd127; sgf_i = {1'b1, 23'h000010, 3'b000}; rmode_i = 2'd0;
    @(posedge clk); #2;
    start_i = 1'b1; exp_i = 9'd200; sgf_i = {1'b1, 23'h000055, 3'b111};
    @(posedge clk); #2;
    start_i = 1'b1;
    @(posedge clk); #2;
    start_i = 1'b0;
    chk("ign_load", 32'(load_o), 32'd1);
    chk("ign_exp",  32'(exp_o),  32'h7F);
    chk("ign_sgf",  32'(sgf_o),  32'h000010);
    @(posedge clk); #2;
    chk("ign_no_second_load", 32'(load_o), 32'd0);
    chk("ign_idle",           32'(busy_o), 32'd0);
    @(posedge clk); #2;
    chk("ign_still_idle",     32'(busy_o), 32'd0);

    // Reset in cycle 2 aborts and clears outputs immediately.
    start_i = 1'b1; sign_i = 1'b1; exp_i = 9'd130; sgf_i = {1'b1, 23'h000007, 3'b000};
    @(posedge clk); #2;
    start_i = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("abort_exp",  32'(exp_o),  32'd0);
    chk("abort_sgf",  32'(sgf_o),  32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #2;
    chk("abort_no_load", 32'(load_o), 32'd0);
    rst = 1'b1;
    @(posedge clk); #2;
    chk("abort_no_load2", 32'(load_o), 32'd0);
    op("post_rst", 1'b0, 9'd127, {1'b1, 23'h000001, 3'b100}, 2'd0, 8'h7F, 23'h000002, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      case ($urandom % 8)
        0:       rnd_e = 9'd0;
        1:       rnd_e = 9'd254;
        2:       rnd_e = 9'd255;
        3:       rnd_e = 9'($urandom_range(256, 511));
        4:       rnd_e = 9'd1;
        default: rnd_e = 9'($urandom_range(1, 253));
      endcase
      rnd_f   = ($urandom % 4 == 0) ? 23'h7FFFFF : 23'($urandom);
      start_i = ($urandom % 3 == 0);
      sign_i  = 1'($urandom);
      rmode_i = 2'($urandom);
      exp_i   = rnd_e;
      sgf_i   = {($urandom % 8 != 0), rnd_f, 3'($urandom)};
      rst     = ($urandom % 150 != 0);
      @(posedge clk); #2;
    end
    start_i = 1'b0;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
